template_grabber: RTL and testbench

- Parametrised successor to the fixed-size template capture block.
- Captures a TPL_W x TPL_H grayscale template from the live pixel stream, sampling every DECIM-th in-box pixel.
- Frame-aligned start, explicit arm/hold/abort control, done pulse and overrun flag.
- Sits between the camera capture path and the correlator; its flattened template output drives correlator template_reg.

---
 rtl/vision_pkg.sv | 14 +
 rtl/tg_raster_counter.sv | 51 +++++
 rtl/template_grabber.sv | 106 ++++++++++
 tb/tb_template_grabber.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vision_pkg.sv
// Shared vision-path types and default template geometry used by the grabber and correlator.
// Pure declarations: no logic, no latency, no flow control.
package vision_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_SOF, CAPTURE, DONE} tg_state_e;

  localparam int TPL_W_DEF = 32;
  localparam int TPL_H_DEF = 32;
  localparam int PIX_W_DEF = 4;

  // Counter width that stays at least one bit wide when the range collapses to 1.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tg_raster_counter.sv
// Decimation, column and row position of the next template write; sample/last are combinational.
// Latency: counters advance on the edge after adv; backpressure: none, adv gates all motion.
module tg_raster_counter
  import vision_pkg::*;
#(
  parameter int TPL_W = TPL_W_DEF,
  parameter int TPL_H = TPL_H_DEF,
  parameter int DECIM = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      adv,
  output logic [cnt_w(TPL_W)-1:0]   col,
  output logic [cnt_w(TPL_H)-1:0]   row,
  output logic                      sample,
  output logic                      last
);
  localparam int CW = cnt_w(TPL_W);
  localparam int RW = cnt_w(TPL_H);
  localparam int DW = cnt_w(DECIM);

  logic [DW-1:0] decim;

  assign sample = adv && (decim == DW'(DECIM - 1));
  assign last   = sample && (col == CW'(TPL_W - 1)) && (row == RW'(TPL_H - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      decim <= '0;
      col   <= '0;
      row   <= '0;
    end else if (clr) begin
      decim <= '0;
      col   <= '0;
      row   <= '0;
    end else if (adv) begin
      if (decim == DW'(DECIM - 1)) begin
        decim <= '0;
        if (col == CW'(TPL_W - 1)) begin
          col <= '0;
          row <= (row == RW'(TPL_H - 1)) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end else begin
        decim <= decim + DW'(1);
      end
    end
  end
endmodule

// File: rtl/template_grabber.sv
// Captures a decimated TPL_W x TPL_H template from the pixel stream; writes land 1 clk after sampling.
// No backpressure: pix_valid is taken every cycle. TEMPLATE_DOUBLE_BUF_EN selects shadow-buffered output.
module template_grabber
  import vision_pkg::*;
#(
  parameter int TPL_W = TPL_W_DEF,
  parameter int TPL_H = TPL_H_DEF,
  parameter int PIX_W = PIX_W_DEF,
  parameter int DECIM = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         frame_start,
  input  logic                         pix_valid,
  input  logic [PIX_W-1:0]             pix_data,
  input  logic                         arm,
  input  logic                         hold,
  input  logic                         abort,
  output logic [TPL_H*TPL_W*PIX_W-1:0] tpl_flat,
  output logic                         tpl_rdy,
  output logic                         done,
  output logic                         busy,
  output logic                         overrun
);
  localparam int N  = TPL_H * TPL_W * PIX_W;
  localparam int IW = cnt_w(N);

  tg_state_e               state;
  logic [cnt_w(TPL_W)-1:0] col;
  logic [cnt_w(TPL_H)-1:0] row;
  logic                    clr, adv, sample, last;
  logic [IW-1:0]           wr_base;

  // A frame_start or abort cycle never captures its own pixel.
  assign adv     = (state == CAPTURE) && pix_valid && !frame_start && !abort;
  assign clr     = abort || (((state == WAIT_SOF) || (state == CAPTURE)) && frame_start);
  assign busy    = (state == WAIT_SOF) || (state == CAPTURE);
  assign wr_base = IW'((int'(row) * TPL_W + int'(col)) * PIX_W);

  tg_raster_counter #(.TPL_W(TPL_W), .TPL_H(TPL_H), .DECIM(DECIM)) u_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (clr),
    .adv    (adv),
    .col    (col),
    .row    (row),
    .sample (sample),
    .last   (last)
  );

`ifdef TEMPLATE_DOUBLE_BUF_EN
  logic [N-1:0] shadow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      shadow <= '0;
    else if (sample) shadow[wr_base +: PIX_W] <= pix_data;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tpl_flat <= '0;
      tpl_rdy  <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: if (arm) begin
            state   <= WAIT_SOF;
            overrun <= 1'b0;
          end
          WAIT_SOF: if (frame_start) begin
            state <= CAPTURE;
`ifndef TEMPLATE_DOUBLE_BUF_EN
            tpl_rdy <= 1'b0;
`endif
          end
          CAPTURE: begin
            if (frame_start) begin
              overrun <= 1'b1;
            end else if (last) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
          DONE: begin
            tpl_rdy <= 1'b1;
`ifdef TEMPLATE_DOUBLE_BUF_EN
            tpl_flat <= shadow;
`endif
            state <= hold ? IDLE : WAIT_SOF;
          end
          default: state <= IDLE;
        endcase
      end
`ifndef TEMPLATE_DOUBLE_BUF_EN
      if (sample) tpl_flat[wr_base +: PIX_W] <= pix_data;
`endif
    end
  end
endmodule

// File: tb/tb_template_grabber.sv
// Two grabbers (DECIM=2 and DECIM=1) on shared stimulus, each checked against a pixel-count model.
module tb_template_grabber;
  localparam int W = 4, H = 4, P = 8, NP = W * H, NB = NP * P;
  localparam int M_IDLE = 0, M_WAIT = 1, M_CAP = 2, M_DONE = 3;
`ifdef TEMPLATE_DOUBLE_BUF_EN
  localparam bit BUF = 1'b1;
`else
  localparam bit BUF = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  logic frame_start = 1'b0, pix_valid = 1'b0, arm = 1'b0, hold = 1'b0, abort = 1'b0;
  logic [P-1:0] pix_data = '0;
  logic [NB-1:0] flat [2];
  logic rdy [2], dn [2], busy [2], ovr [2];

  int total = 0, bad = 0;
  int dc [2];
  int ms [2], k [2];
  logic [NB-1:0] mflat [2], mshadow [2];
  bit mrdy [2], mdone [2], movr [2];

  always #5 clk = ~clk;

  template_grabber #(.TPL_W(W), .TPL_H(H), .PIX_W(P), .DECIM(2)) dut0 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_data(pix_data), .arm(arm), .hold(hold), .abort(abort), .tpl_flat(flat[0]),
    .tpl_rdy(rdy[0]), .done(dn[0]), .busy(busy[0]), .overrun(ovr[0]));

  template_grabber #(.TPL_W(W), .TPL_H(H), .PIX_W(P), .DECIM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .pix_valid(pix_valid),
    .pix_data(pix_data), .arm(arm), .hold(hold), .abort(abort), .tpl_flat(flat[1]),
    .tpl_rdy(rdy[1]), .done(dn[1]), .busy(busy[1]), .overrun(ovr[1]));

  function automatic int dec_of(input int i);
    return (i == 0) ? 2 : 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      ms[i] = M_IDLE; k[i] = 0; mflat[i] = '0; mshadow[i] = '0;
      mrdy[i] = 1'b0; mdone[i] = 1'b0; movr[i] = 1'b0;
    end
  endtask

  // k counts in-box pixels accepted since capture start; every DECIM-th one fills slot k/DECIM.
  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      int d;
      d = dec_of(i);
      mdone[i] = 1'b0;
      if (abort) begin
        ms[i] = M_IDLE; k[i] = 0;
      end else begin
        case (ms[i])
          M_IDLE: if (arm) begin ms[i] = M_WAIT; movr[i] = 1'b0; end
          M_WAIT: if (frame_start) begin
            ms[i] = M_CAP; k[i] = 0;
            if (!BUF) mrdy[i] = 1'b0;
          end
          M_CAP: begin
            if (frame_start) begin
              k[i] = 0; movr[i] = 1'b1;
            end else if (pix_valid) begin
              if (k[i] % d == d - 1) begin
                if (BUF) mshadow[i][(k[i] / d) * P +: P] = pix_data;
                else     mflat[i][(k[i] / d) * P +: P] = pix_data;
              end
              k[i]++;
              if (k[i] == NP * d) begin ms[i] = M_DONE; mdone[i] = 1'b1; end
            end
          end
          default: begin
            mrdy[i] = 1'b1;
            if (BUF) mflat[i] = mshadow[i];
            ms[i] = hold ? M_IDLE : M_WAIT;
          end
        endcase
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < 2; i++) if (dn[i]) dc[i]++;
  endtask

  task automatic idle(input int n);
    repeat (n) begin pix_data = P'($urandom); tick(); end
  endtask

  task automatic pixel(input logic [P-1:0] v, output bit d0, output bit d1);
    pix_valid = 1'b1; pix_data = v;
    tick();
    d0 = dn[0]; d1 = dn[1];
    pix_valid = 1'b0;
    idle($urandom_range(0, 2));
  endtask

  task automatic pulse_fs();
    frame_start = 1'b1; pix_valid = 1'b1; pix_data = P'($urandom);
    tick();
    frame_start = 1'b0; pix_valid = 1'b0;
  endtask

  task automatic pulse_arm();
    arm = 1'b1; tick(); arm = 1'b0;
  endtask

  task automatic test_reset();
    idle(2);
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({flat[i], rdy[i], dn[i], busy[i], ovr[i]} !== {NB'(0), 4'b0}) begin
        bad++; $display("FAIL reset inst%0d got=%0h want=0", i, {flat[i], rdy[i], dn[i], busy[i], ovr[i]});
      end
    end
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic test_decim_hold();
    logic [NB-1:0] e_odd, e_seq;
    bit d0, d1;
    hold = 1'b1; dc[0] = 0; dc[1] = 0;
    pulse_arm();
    total++;
    if (busy[0] !== 1'b1 || busy[1] !== 1'b1) begin
      bad++; $display("FAIL arm_busy got=%b%b want=11", busy[0], busy[1]);
    end
    pulse_fs();
    for (int v = 0; v < 32; v++) begin
      pixel(P'(v), d0, d1);
      total++;
      if (d0 !== (v == 31) || d1 !== (v == 15)) begin
        bad++; $display("FAIL done_pos pix=%0d got=%b%b want=%b%b", v, d0, d1, v == 31, v == 15);
      end
    end
    idle(2);
    for (int i = 0; i < NP; i++) begin
      e_odd[i*P +: P] = P'(2 * i + 1);
      e_seq[i*P +: P] = P'(i);
    end
    total++;
    if (flat[0] !== e_odd) begin bad++; $display("FAIL odd_tpl got=%0h want=%0h", flat[0], e_odd); end
    total++;
    if (flat[1] !== e_seq) begin bad++; $display("FAIL seq_tpl got=%0h want=%0h", flat[1], e_seq); end
    total++;
    if ({dc[0][1:0], dc[1][1:0], rdy[0], rdy[1], busy[0], busy[1]} !== 8'b01_01_11_00) begin
      bad++; $display("FAIL hold_end got=%0d %0d %b%b %b%b want=1 1 11 00", dc[0], dc[1], rdy[0], rdy[1], busy[0], busy[1]);
    end
  endtask

  task automatic test_refresh();
    bit d0, d1;
    logic [NB-1:0] all9;
    hold = 1'b0; dc[0] = 0; dc[1] = 0;
    pulse_arm();
    pulse_fs();
    for (int v = 0; v < NP; v++) pixel(8'd5, d0, d1);
    idle(2);
    pulse_fs();
    for (int v = 0; v < NP; v++) pixel(8'd9, d0, d1);
    idle(2);
    all9 = {NP{8'd9}};
    total++;
    if (dc[1] !== 2) begin bad++; $display("FAIL refresh_done got=%0d want=2", dc[1]); end
    total++;
    if (flat[1] !== all9) begin bad++; $display("FAIL refresh_tpl got=%0h want=%0h", flat[1], all9); end
    total++;
    if ({rdy[1], busy[1], ovr[0]} !== 3'b111) begin
      bad++; $display("FAIL refresh_flags got=%b%b%b want=111", rdy[1], busy[1], ovr[0]);
    end
    total++;
    if (flat[0] !== mflat[0]) begin bad++; $display("FAIL refresh_partial got=%0h want=%0h", flat[0], mflat[0]); end
    abort = 1'b1; tick(); abort = 1'b0;
    total++;
    if (busy[0] !== 1'b0 || busy[1] !== 1'b0) begin bad++; $display("FAIL refresh_abort got=%b%b want=00", busy[0], busy[1]); end
  endtask

  task automatic test_overrun();
    bit d0, d1;
    hold = 1'b1; dc[0] = 0;
    pulse_arm();
    total++;
    if (ovr[0] !== 1'b0) begin bad++; $display("FAIL arm_clears_ovr got=%b want=0", ovr[0]); end
    pulse_fs();
    for (int v = 0; v < 16; v++) pixel(P'($urandom), d0, d1);
    pulse_fs();
    total++;
    if ({ovr[0], busy[0], ovr[1], rdy[0]} !== {3'b110, BUF}) begin
      bad++; $display("FAIL overrun_set got=%b%b%b%b want=110%b", ovr[0], busy[0], ovr[1], rdy[0], BUF);
    end
    for (int v = 0; v < 32; v++) begin
      pixel(P'($urandom), d0, d1);
      total++;
      if (d0 !== (v == 31)) begin bad++; $display("FAIL ovr_done pix=%0d got=%b want=%b", v, d0, v == 31); end
    end
    idle(2);
    total++;
    if (flat[0] !== mflat[0] || dc[0] !== 1) begin
      bad++; $display("FAIL ovr_tpl got=%0h/%0d want=%0h/1", flat[0], dc[0], mflat[0]);
    end
    pulse_arm();
    total++;
    if (ovr[0] !== 1'b0 || busy[0] !== 1'b1) begin bad++; $display("FAIL ovr_clear got=%b%b want=01", ovr[0], busy[0]); end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_abort();
    bit d0, d1;
    hold = 1'b1; dc[0] = 0; dc[1] = 0;
    pulse_arm();
    pulse_fs();
    for (int v = 0; v < 10; v++) pixel(P'($urandom), d0, d1);
    abort = 1'b1; arm = 1'b1; pix_valid = 1'b1;
    tick();
    abort = 1'b0; arm = 1'b0; pix_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({busy[i], dn[i]} !== 2'b00 || flat[i] !== mflat[i]) begin
        bad++; $display("FAIL abort inst%0d got=%b%b %0h want=00 %0h", i, busy[i], dn[i], flat[i], mflat[i]);
      end
    end
    pulse_fs();
    idle(3);
    total++;
    if (busy[0] !== 1'b0 || dc[0] !== 0 || dc[1] !== 0) begin
      bad++; $display("FAIL abort_stays got=%b %0d %0d want=0 0 0", busy[0], dc[0], dc[1]);
    end
  endtask

  task automatic test_double_buf();
    logic [NB-1:0] all3, all7;
    bit seen3 = 1'b0;
    all3 = {NP{8'd3}}; all7 = {NP{8'd7}};
    hold = 1'b0;
    pulse_arm();
    for (int c = 0; c < 76; c++) begin
      frame_start = (c == 0) || (c == 37);
      pix_valid = (c >= 1 && c <= 32) || (c >= 38 && c <= 69);
      pix_data = (c < 37) ? 8'd3 : 8'd7;
      tick();
      if (flat[0] === all3) seen3 = 1'b1;
      total++;
      if ((seen3 && flat[0] !== all3 && flat[0] !== all7) || rdy[0] !== 1'b1) begin
        bad++; $display("FAIL dbuf_mix cyc=%0d got=%0h rdy=%b want=all3/all7 rdy=1", c, flat[0], rdy[0]);
      end
    end
    frame_start = 1'b0; pix_valid = 1'b0;
    total++;
    if (!seen3 || flat[0] !== all7) begin bad++; $display("FAIL dbuf_final got=%0h seen3=%b want=%0h", flat[0], seen3, all7); end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 3000; c++) begin
      frame_start = ($urandom_range(0, 59) == 0);
      pix_valid = ($urandom_range(0, 3) != 0);
      pix_data = P'($urandom);
      arm = ($urandom_range(0, 7) == 0);
      abort = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 99) == 0) hold = ~hold;
      tick();
      for (int i = 0; i < 2; i++) begin
        total++;
        if ({flat[i], rdy[i], dn[i], busy[i], ovr[i]} !==
            {mflat[i], mrdy[i], mdone[i], (ms[i] == M_WAIT || ms[i] == M_CAP), movr[i]}) begin
          bad++;
          $display("FAIL random cyc=%0d inst%0d got=%0h %b%b%b%b want=%0h %b%b%b%b", c, i, flat[i], rdy[i], dn[i], busy[i], ovr[i],
                   mflat[i], mrdy[i], mdone[i], (ms[i] == M_WAIT || ms[i] == M_CAP), movr[i]);
        end
      end
    end
    frame_start = 1'b0; pix_valid = 1'b0; arm = 1'b0;
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_async_reset();
    bit d0, d1;
    hold = 1'b1;
    pulse_arm();
    pulse_fs();
    for (int v = 0; v < 5; v++) pixel(P'($urandom), d0, d1);
    pix_valid = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if ({flat[i], rdy[i], dn[i], busy[i], ovr[i]} !== {NB'(0), 4'b0}) begin
        bad++; $display("FAIL async_rst inst%0d got=%0h want=0", i, {flat[i], rdy[i], dn[i], busy[i], ovr[i]});
      end
    end
    pix_valid = 1'b0;
    tick();
    #3 rst_n = 1'b1;
    dc[0] = 0; dc[1] = 0;
    pulse_fs();
    for (int v = 0; v < 32; v++) pixel(P'($urandom), d0, d1);
    idle(2);
    total++;
    if (busy[0] !== 1'b0 || dc[0] !== 0 || dc[1] !== 0 || flat[0] !== NB'(0)) begin
      bad++; $display("FAIL no_arm_no_capture got=%b %0d %0d %0h want=0 0 0 0", busy[0], dc[0], dc[1], flat[0]);
    end
    pulse_arm();
    pulse_fs();
    for (int v = 0; v < 32; v++) pixel(P'($urandom), d0, d1);
    idle(2);
    total++;
    if (dc[0] !== 1 || flat[0] !== mflat[0] || rdy[0] !== 1'b1) begin
      bad++; $display("FAIL rearm_capture got=%0d %0h %b want=1 %0h 1", dc[0], flat[0], rdy[0], mflat[0]);
    end
  endtask

  initial begin
    model_reset();
    dc[0] = 0; dc[1] = 0;
    test_reset();
    test_decim_hold();
    test_refresh();
    test_overrun();
    test_abort();
    if (BUF) test_double_buf();
    test_random();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
